// File: rtl/fifo_sys_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// fifo_sys_ctrl_fsm
//
// Moore sequencer for the FIFO subsystem (main FIFO, VC0, VC1, D0, D1).
// After reset it passes through INIT, where the per-FIFO almost-empty /
// almost-full thresholds are captured, then alternates between IDLE and
// ACTIVE depending on whether every FIFO is empty. Any reported FIFO error
// moves it to ERROR, which only reset can leave. Error bits are recorded
// stickily in errors_out.
//
// Ports:
//   clk                  system clock, rising-edge active
//   reset                asynchronous, active-low reset
//   init                 request to (re)enter INIT and load thresholds
//   *_low / *_high       threshold inputs for main, VC0, VC1, D0, D1
//   empties[N_FIFO-1:0]  per-FIFO empty flags (0 main, 1 VC0, 2 VC1, 3 D0, 4 D1)
//   errors[N_FIFO-1:0]   per-FIFO error pulses, same bit order
//   state[4:0]           one-hot current state
//   idle_out             state is IDLE
//   active_out           state is ACTIVE
//   error_out            state is ERROR
//   errors_out           sticky OR of all error pulses seen since reset
//   *_low_out/*_high_out registered threshold copies
// -----------------------------------------------------------------------------
module fifo_sys_ctrl_fsm #(
    parameter int TH_W   = 5,
    parameter int N_FIFO = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [TH_W-1:0]   main_fifo_low,
    input  logic [TH_W-1:0]   main_fifo_high,
    input  logic [TH_W-1:0]   Vc0_low,
    input  logic [TH_W-1:0]   Vc0_high,
    input  logic [TH_W-1:0]   Vc1_low,
    input  logic [TH_W-1:0]   Vc1_high,
    input  logic [TH_W-1:0]   D0_low,
    input  logic [TH_W-1:0]   D0_high,
    input  logic [TH_W-1:0]   D1_low,
    input  logic [TH_W-1:0]   D1_high,
    input  logic [N_FIFO-1:0] empties,
    input  logic [N_FIFO-1:0] errors,
    output logic [4:0]        state,
    output logic              idle_out,
    output logic              active_out,
    output logic              error_out,
    output logic [N_FIFO-1:0] errors_out,
    output logic [TH_W-1:0]   main_fifo_low_out,
    output logic [TH_W-1:0]   main_fifo_high_out,
    output logic [TH_W-1:0]   Vc0_low_out,
    output logic [TH_W-1:0]   Vc0_high_out,
    output logic [TH_W-1:0]   Vc1_low_out,
    output logic [TH_W-1:0]   Vc1_high_out,
    output logic [TH_W-1:0]   D0_low_out,
    output logic [TH_W-1:0]   D0_high_out,
    output logic [TH_W-1:0]   D1_low_out,
    output logic [TH_W-1:0]   D1_high_out
);

    localparam int N_TH = 10;

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [N_FIFO-1:0]   errors_reg;
    logic [TH_W-1:0]     th_in  [N_TH];
    logic [TH_W-1:0]     th_reg [N_TH];

    logic any_error;
    logic all_empty;

    assign any_error = |errors;
    assign all_empty = &empties;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Errors are checked first in every operational state so
    // they win over init requests and emptiness changes on the same edge.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RESET: begin
                state_next = ST_INIT;
            end
            ST_INIT: begin
                if (any_error) begin
                    state_next = ST_ERROR;
                end else if (!init) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (any_error) begin
                    state_next = ST_ERROR;
                end else if (init) begin
                    state_next = ST_INIT;
                end else if (!all_empty) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (any_error) begin
                    state_next = ST_ERROR;
                end else if (init) begin
                    state_next = ST_INIT;
                end else if (all_empty) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                // Corrupted encoding: restart the sequence cleanly.
                state_next = ST_RESET;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sticky error record. Accumulates in every state except RESET, so the bits
    // that trigger the ERROR transition land on the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            errors_reg <= '0;
        end else if (state_reg != ST_RESET) begin
            errors_reg <= errors_reg | errors;
        end
    end

    // -------------------------------------------------------------------------
    // Threshold capture: loaded on every edge spent in INIT, held otherwise.
    // -------------------------------------------------------------------------
    assign th_in[0] = main_fifo_low;
    assign th_in[1] = main_fifo_high;
    assign th_in[2] = Vc0_low;
    assign th_in[3] = Vc0_high;
    assign th_in[4] = Vc1_low;
    assign th_in[5] = Vc1_high;
    assign th_in[6] = D0_low;
    assign th_in[7] = D0_high;
    assign th_in[8] = D1_low;
    assign th_in[9] = D1_high;

    generate
        for (genvar gi = 0; gi < N_TH; gi++) begin : g_th
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    th_reg[gi] <= '0;
                end else if (state_reg == ST_INIT) begin
                    th_reg[gi] <= th_in[gi];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs: all taken straight from registers.
    // -------------------------------------------------------------------------
    assign state      = state_reg;
    assign idle_out   = state_reg[2];
    assign active_out = state_reg[3];
    assign error_out  = state_reg[4];
    assign errors_out = errors_reg;

    assign main_fifo_low_out  = th_reg[0];
    assign main_fifo_high_out = th_reg[1];
    assign Vc0_low_out        = th_reg[2];
    assign Vc0_high_out       = th_reg[3];
    assign Vc1_low_out        = th_reg[4];
    assign Vc1_high_out       = th_reg[5];
    assign D0_low_out         = th_reg[6];
    assign D0_high_out        = th_reg[7];
    assign D1_low_out         = th_reg[8];
    assign D1_high_out        = th_reg[9];

endmodule

// File: tb/tb_fifo_sys_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_fifo_sys_ctrl_fsm
//
// Self-checking bench for fifo_sys_ctrl_fsm. Each scenario task drives a short
// stimulus table; for every step the expected observation vector
// {state, idle, active, error, errors_out, 10 thresholds} is pushed onto a
// scoreboard queue, the clock advances, and the entry is popped and compared
// against the DUT outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_sys_ctrl_fsm;

    localparam int TH_W   = 5;
    localparam int N_FIFO = 5;
    localparam int VW     = 5 + 3 + N_FIFO + 10 * TH_W;

    localparam logic [4:0] S_RESET  = 5'b00001;
    localparam logic [4:0] S_INIT   = 5'b00010;
    localparam logic [4:0] S_IDLE   = 5'b00100;
    localparam logic [4:0] S_ACTIVE = 5'b01000;
    localparam logic [4:0] S_ERROR  = 5'b10000;

    logic              clk;
    logic              reset;
    logic              init;
    logic [TH_W-1:0]   th_drv [10];
    logic [N_FIFO-1:0] empties;
    logic [N_FIFO-1:0] errors;

    logic [4:0]        state;
    logic              idle_out, active_out, error_out;
    logic [N_FIFO-1:0] errors_out;
    logic [TH_W-1:0]   th_obs [10];

    int checks = 0;
    int errs   = 0;

    logic [VW-1:0] sb [$];

    fifo_sys_ctrl_fsm #(.TH_W(TH_W), .N_FIFO(N_FIFO)) dut (
        .clk                (clk),
        .reset              (reset),
        .init               (init),
        .main_fifo_low      (th_drv[0]),
        .main_fifo_high     (th_drv[1]),
        .Vc0_low            (th_drv[2]),
        .Vc0_high           (th_drv[3]),
        .Vc1_low            (th_drv[4]),
        .Vc1_high           (th_drv[5]),
        .D0_low             (th_drv[6]),
        .D0_high            (th_drv[7]),
        .D1_low             (th_drv[8]),
        .D1_high            (th_drv[9]),
        .empties            (empties),
        .errors             (errors),
        .state              (state),
        .idle_out           (idle_out),
        .active_out         (active_out),
        .error_out          (error_out),
        .errors_out         (errors_out),
        .main_fifo_low_out  (th_obs[0]),
        .main_fifo_high_out (th_obs[1]),
        .Vc0_low_out        (th_obs[2]),
        .Vc0_high_out       (th_obs[3]),
        .Vc1_low_out        (th_obs[4]),
        .Vc1_high_out       (th_obs[5]),
        .D0_low_out         (th_obs[6]),
        .D0_high_out        (th_obs[7]),
        .D1_low_out         (th_obs[8]),
        .D1_high_out        (th_obs[9])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed DUT outputs packed in the same layout as mk_exp.
    function automatic logic [VW-1:0] obs();
        logic [10*TH_W-1:0] t;
        for (int i = 0; i < 10; i++) t[(9-i)*TH_W +: TH_W] = th_obs[i];
        return {state, idle_out, active_out, error_out, errors_out, t};
    endfunction

    // Expected vector: flags follow from the one-hot state bits 2, 3, 4.
    function automatic logic [VW-1:0] mk_exp(logic [4:0] st, logic [N_FIFO-1:0] eo,
                                             logic [10*TH_W-1:0] th);
        return {st, st[2], st[3], st[4], eo, th};
    endfunction

    task automatic set_all_th(input logic [TH_W-1:0] v);
        for (int i = 0; i < 10; i++) th_drv[i] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic [VW-1:0] e, o;
        reset = 1'b0; init = 1'b1; empties = '1; errors = '0;
        set_all_th(5'h1F);
        for (int c = 0; c < 2; c++) begin
            sb.push_back(mk_exp(S_RESET, '0, '0));
            tick();
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errs++;
                $display("FAIL reset_hold[%0d] got=%h want=%h", c, o, e);
            end
        end
        // First edge after release goes to INIT; thresholds not yet captured.
        reset = 1'b1;
        sb.push_back(mk_exp(S_INIT, '0, '0));
        tick();
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin
            errs++;
            $display("FAIL reset_release got=%h want=%h", o, e);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_threshold_capture();
        logic [VW-1:0] e, o;
        logic [TH_W-1:0]    vals [10];
        logic [10*TH_W-1:0] tv;
        logic [4:0]         st_tab [4];
        logic               init_tab [4];
        logic               zero_tab [4];
        vals = '{5'h3, 5'h6, 5'hB, 5'h8, 5'hA, 5'h7, 5'hC, 5'h9, 5'hD, 5'hA};
        tv = {5'h3, 5'h6, 5'hB, 5'h8, 5'hA, 5'h7, 5'hC, 5'h9, 5'hD, 5'hA};
        st_tab   = '{S_INIT, S_IDLE, S_IDLE, S_IDLE};
        init_tab = '{1'b1, 1'b0, 1'b0, 1'b0};
        zero_tab = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int s = 0; s < 4; s++) begin
            init = init_tab[s];
            for (int i = 0; i < 10; i++) th_drv[i] = zero_tab[s] ? '0 : vals[i];
            sb.push_back(mk_exp(st_tab[s], '0, tv));
            tick();
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errs++;
                $display("FAIL th_capture[%0d] got=%h want=%h", s, o, e);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_active();
        logic [VW-1:0] e, o;
        logic [10*TH_W-1:0] tv;
        logic [N_FIFO-1:0]  emp_tab [5];
        logic [4:0]         st_tab  [5];
        tv = {5'h3, 5'h6, 5'hB, 5'h8, 5'hA, 5'h7, 5'hC, 5'h9, 5'hD, 5'hA};
        emp_tab = '{5'h1E, 5'h00, 5'h1F, 5'h1F, 5'h0F};
        st_tab  = '{S_ACTIVE, S_ACTIVE, S_IDLE, S_IDLE, S_ACTIVE};
        for (int s = 0; s < 5; s++) begin
            empties = emp_tab[s];
            sb.push_back(mk_exp(st_tab[s], '0, tv));
            tick();
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errs++;
                $display("FAIL active[%0d] got=%h want=%h", s, o, e);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Starts in ACTIVE. Error beats a simultaneous init; ERROR then ignores
    // init and empties while still accumulating error bits.
    task automatic test_error();
        logic [VW-1:0] e, o;
        logic [10*TH_W-1:0] tv;
        logic [N_FIFO-1:0]  err_tab  [5];
        logic               init_tab [5];
        logic [N_FIFO-1:0]  emp_tab  [5];
        logic [N_FIFO-1:0]  eo_tab   [5];
        tv = {5'h3, 5'h6, 5'hB, 5'h8, 5'hA, 5'h7, 5'hC, 5'h9, 5'hD, 5'hA};
        err_tab  = '{5'h04, 5'h00, 5'h01, 5'h00, 5'h00};
        init_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        emp_tab  = '{5'h0F, 5'h1F, 5'h1F, 5'h00, 5'h1F};
        eo_tab   = '{5'h04, 5'h04, 5'h05, 5'h05, 5'h05};
        for (int s = 0; s < 5; s++) begin
            errors = err_tab[s]; init = init_tab[s]; empties = emp_tab[s];
            set_all_th(5'h07);
            sb.push_back(mk_exp(S_ERROR, eo_tab[s], tv));
            tick();
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errs++;
                $display("FAIL error[%0d] got=%h want=%h", s, o, e);
            end
        end
        errors = '0;
    endtask

    // -------------------------------------------------------------------------
    // Reset asserted mid-cycle must clear everything before the next edge.
    task automatic test_async_reset();
        logic [VW-1:0] e, o;
        logic [4:0] st_tab [2];
        logic [10*TH_W-1:0] th_tab [2];
        #2;
        reset = 1'b0;
        sb.push_back(mk_exp(S_RESET, '0, '0));
        #1;
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin
            errs++;
            $display("FAIL async_reset got=%h want=%h", o, e);
        end
        @(negedge clk);
        reset = 1'b1; init = 1'b0; empties = '1; errors = '0;
        set_all_th(5'h15);
        // RESET -> INIT -> IDLE with a single INIT cycle that captures 5'h15.
        st_tab = '{S_INIT, S_IDLE};
        th_tab = '{'0, {10{5'h15}}};
        for (int s = 0; s < 2; s++) begin
            sb.push_back(mk_exp(st_tab[s], '0, th_tab[s]));
            tick();
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errs++;
                $display("FAIL restart[%0d] got=%h want=%h", s, o, e);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Re-entry into INIT reloads thresholds without clearing them first.
    task automatic test_reinit();
        logic [VW-1:0] e, o;
        logic               init_tab [3];
        logic [4:0]         st_tab   [3];
        logic [10*TH_W-1:0] th_tab   [3];
        init_tab = '{1'b1, 1'b1, 1'b0};
        st_tab   = '{S_INIT, S_INIT, S_IDLE};
        th_tab   = '{{10{5'h15}}, {10{5'h11}}, {10{5'h11}}};
        set_all_th(5'h11);
        for (int s = 0; s < 3; s++) begin
            init = init_tab[s];
            sb.push_back(mk_exp(st_tab[s], '0, th_tab[s]));
            tick();
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errs++;
                $display("FAIL reinit[%0d] got=%h want=%h", s, o, e);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Error arriving while in INIT wins over the pending init request.
    task automatic test_init_error();
        logic [VW-1:0] e, o;
        logic [N_FIFO-1:0]  err_tab [2];
        logic [4:0]         st_tab  [2];
        logic [N_FIFO-1:0]  eo_tab  [2];
        logic [10*TH_W-1:0] th_tab  [2];
        err_tab = '{5'h00, 5'h12};
        st_tab  = '{S_INIT, S_ERROR};
        eo_tab  = '{5'h00, 5'h12};
        th_tab  = '{{10{5'h11}}, {10{5'h09}}};
        init = 1'b1;
        set_all_th(5'h09);
        for (int s = 0; s < 2; s++) begin
            errors = err_tab[s];
            sb.push_back(mk_exp(st_tab[s], eo_tab[s], th_tab[s]));
            tick();
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin
                errs++;
                $display("FAIL init_error[%0d] got=%h want=%h", s, o, e);
            end
        end
        errors = '0;
    endtask

    initial begin
        test_reset();
        test_threshold_capture();
        test_active();
        test_error();
        test_async_reset();
        test_reinit();
        test_init_error();
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule

// File: doc/fifo_sys_ctrl_fsm.md
Name: fifo_sys_ctrl_fsm

Overview:
Moore state machine that sequences the FIFO subsystem: main FIFO, virtual-channel FIFOs VC0/VC1 and destination FIFOs D0/D1. It leaves reset, captures per-FIFO almost-empty/almost-full thresholds during an INIT phase, then runs in IDLE/ACTIVE according to FIFO emptiness. Any FIFO error reported to it is made sticky. Its registered threshold outputs drive the FIFO flag comparators, and its state flags gate the subsystem datapath.

Parameters:
TH_W, 5, width of every threshold field
N_FIFO, 5, number of monitored FIFOs (main, VC0, VC1, D0, D1); width of empties/errors

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
init  in  1  request to (re)enter INIT and load thresholds
main_fifo_low  in  TH_W  main FIFO almost-empty threshold
main_fifo_high  in  TH_W  main FIFO almost-full threshold
Vc0_low, Vc0_high  in  TH_W each  VC0 thresholds
Vc1_low, Vc1_high  in  TH_W each  VC1 thresholds
D0_low, D0_high  in  TH_W each  D0 thresholds
D1_low, D1_high  in  TH_W each  D1 thresholds
empties  in  N_FIFO  per-FIFO empty flags; bit0 main, 1 VC0, 2 VC1, 3 D0, 4 D1
errors  in  N_FIFO  per-FIFO error pulses (overflow/underflow); same bit order
state  out  5  one-hot current state
idle_out  out  1  1 when state is IDLE
active_out  out  1  1 when state is ACTIVE
error_out  out  1  1 when state is ERROR
errors_out  out  N_FIFO  sticky record of which FIFOs flagged an error
main_fifo_low_out ... D1_high_out  out  TH_W each  registered threshold copies, 10 outputs mirroring the inputs

Behaviour:
- Reset is asynchronous and active-low. reset=0 forces state=RESET (5'b00001) immediately. All other outputs go to 0 immediately: flags, errors_out and all 10 threshold outputs.
- State encoding is one-hot: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.
- The block is Moore. Every output is registered and depends only on registered state and data. A transition condition sampled at edge N shows on the outputs after edge N.
- Transition priority within each state runs top to bottom:
  - RESET: unconditionally go to INIT on the first edge with reset=1.
  - INIT: if errors!=0, go to ERROR. Else if init=0, go to IDLE. Else stay in INIT.
  - IDLE: if errors!=0, go to ERROR. Else if init=1, go to INIT. Else if empties!=all-ones, go to ACTIVE. Else stay in IDLE.
  - ACTIVE: if errors!=0, go to ERROR. Else if init=1, go to INIT. Else if empties==all-ones, go to IDLE. Else stay in ACTIVE.
  - ERROR: stay in ERROR. Only reset=0 leaves it; init and empties are ignored.
- Minimum dwell in INIT is 1 cycle, even if init=0.
- Threshold capture: at every edge where current state is INIT, all 10 *_out registers load their inputs.
  - Outside INIT the registers hold their value.
  - Input changes outside INIT must not appear on the outputs.
  - Re-entering INIT from IDLE or ACTIVE reloads the registers; it does not clear them first.
- No low<high validation; values pass through unmodified at full TH_W width.
- errors_out: at every edge in a state other than RESET, errors_out <= errors_out | errors. It is cleared only by reset.
  - The error bits that cause the ERROR transition are recorded on the same edge.
- Simultaneous events: errors!=0 beats init=1 and beats empties changes.
- Reset asserted mid-operation (any state, any phase of the clock) aborts immediately. The block restarts from RESET, and the thresholds return to 0.
- idle_out, active_out and error_out equal state[2], state[3] and state[4] respectively.

Test Plan:
1. Hold reset=0 for 2 cycles with thresholds=5'h1F, then release -> state=00001 during reset; all outputs 0; state=00010 on the first edge after release.
2. In INIT with init=1, set main_fifo_low=3, Vc1_low=A, Vc0_low=B, D0_low=C, D1_low=D, main_fifo_high=6, Vc1_high=7, Vc0_high=8, D0_high=9, D1_high=A, then drop init -> the *_out values equal the inputs one edge later; state goes to IDLE. Then change all inputs to 0 while in IDLE -> the *_out values keep their prior values.
3. From IDLE, drive empties=5'h1E -> state goes to ACTIVE and active_out=1 next edge. Then drive empties=5'h1F -> state goes back to IDLE next edge.
4. In ACTIVE, pulse errors=5'h04 for 1 cycle together with init=1 -> state=ERROR (not INIT), errors_out=5'h04. Later pulse errors=5'h01 -> errors_out=5'h05. Toggle init and empties -> the block stays in ERROR.
5. In ERROR, assert reset=0 mid-cycle -> state=00001 and all outputs 0 without waiting for a clock edge. Then release -> RESET, INIT, IDLE sequence with init=0.
6. In IDLE, raise init=1 with new thresholds 5'h11 -> the block enters INIT and *_out=5'h11. Then drop init -> IDLE.
